rom_port_arbiter: RTL and testbench
===================================

Name: rom_port_arbiter

Overview:
- Shares the single-port 1024x32 instruction/asset ROM between two Avalon-MM-style requesters.
- Master 0 is the CPU data port: read and write, with writes acting as debug/runtime patching. Master 1 is the video/sprite fetch engine: read-only.
- Round-robin arbitration with a bounded hold window, so a streaming sprite fetch cannot starve the CPU.
- Drives the memory's address/chipselect/write/debugaccess pins and returns read data with a fixed 1-cycle latency.

Parameters:
- ADDR_W, 10, word address width (1024 words)
- DATA_W, 32, data width
- BE_W, 4, byteenable width (DATA_W/8)
- MAX_HOLD, 4, max consecutive accesses granted to one master while the other is requesting (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m0_read  in  1  CPU read request
- m0_write  in  1  CPU write request
- m0_address  in  ADDR_W  CPU word address
- m0_writedata  in  DATA_W  CPU write data
- m0_byteenable  in  BE_W  CPU byte enables
- m0_waitrequest  out  1  high = m0 request not accepted this cycle
- m0_readdata  out  DATA_W  read data to CPU
- m0_readdatavalid  out  1  m0_readdata valid
- m1_read  in  1  fetch read request
- m1_address  in  ADDR_W  fetch word address
- m1_waitrequest  out  1  high = m1 request not accepted
- m1_readdata  out  DATA_W  read data to fetch engine
- m1_readdatavalid  out  1  m1_readdata valid
- mem_address  out  ADDR_W  to memory address
- mem_byteenable  out  BE_W  to memory byteenable
- mem_chipselect  out  1  to memory chipselect
- mem_write  out  1  to memory write
- mem_debugaccess  out  1  to memory debugaccess (write enable qualifier)
- mem_writedata  out  DATA_W  to memory writedata
- mem_readdata  in  DATA_W  from memory (valid one clk after address is presented)

Behaviour:
- Request rules: req0 = m0_read|m0_write; req1 = m1_read. If m0_read and m0_write are both high, the access is a write.
- Accept semantics: exactly one master is granted per cycle, combinationally. The granted master sees waitrequest=0 and its access is accepted on that clk edge. The other master sees waitrequest=1 and must hold its request stable.
- Owner FSM, registered states:
  - IDLE: both requesting → grant the master not equal to last_grant; one requesting → grant it. Next state = OWN of the granted master.
  - OWN0 / OWN1: owner still requesting and (hold_cnt < MAX_HOLD-1 or other idle) → grant owner, hold_cnt++ (saturating). Owner requesting, hold_cnt == MAX_HOLD-1, other requesting → grant other, switch state, hold_cnt=0. Owner idle and other requesting → grant other, switch, hold_cnt=0. Neither requesting → no grant, next IDLE.
  - last_grant updates on every accepted access.
- Memory drive: mem_address/mem_byteenable/mem_writedata are muxed from the granted master. Master 1 always uses byteenable all-ones. mem_chipselect = any grant. mem_write = mem_debugaccess = grant0 & m0_write. With no grant, mem_address holds its last value and chipselect/write/debugaccess are 0.
- Read return:
  - An accepted read registers rd_pend=1 and rd_owner.
  - Next cycle, readdatavalid of rd_owner = 1 and its readdata = mem_readdata. The other master's readdata = 0.
  - Reads pipeline back-to-back at one per cycle, with no bubble on owner switch.
- Writes produce no readdatavalid. A write followed by a read of the same address returns the new data. The memory is unregistered-output and write-first at word level; this is the required behaviour.
- Reset, asserted asynchronously: state=IDLE, hold_cnt=0, last_grant=1 (so m0 wins the first tie), rd_pend=0. Both waitrequest=1, both readdatavalid=0, both readdata=0. mem_chipselect/mem_write/mem_debugaccess=0, mem_address=0.
- Reset mid-read: a pending readdatavalid is dropped. No response after deassertion.
- Deassertion: waitrequest drops no earlier than the first clk after reset falls.

Decomposition:
- Shared package rom_arb_pkg: owner state enum (IDLE, OWN0, OWN1) and MASTER_CPU=0 / MASTER_FETCH=1 constants.
- One sub-module: rom_rr_grant. Combinational grant and next-state logic from (state, req0, req1, hold_cnt, last_grant), which can be unit-tested alone.
- Read-return pipeline and memory mux stay in the top.

Test Plan:
- m0 read addr 0x005 alone (mem word 0xDEADBEEF) → m0_waitrequest=0 same cycle; next cycle m0_readdatavalid=1, m0_readdata=0xDEADBEEF; m1_readdatavalid=0.
- req0 and req1 raised together after reset → m0 granted first, m1 next cycle, alternating while both single-shot; valids 1 cycle after each grant.
- MAX_HOLD=4: m1 streams 10 reads (0x100..0x109), m0 holds a read of 0x020 from cycle 1 → m1 gets 4 grants, m0 1 grant, m1 resumes; m0 waits at most 4 cycles.
- m0 write 0x010 data 0x11223344 be=0011, then read 0x010 (old 0xAABBCCDD) → mem_write=mem_debugaccess=1 for one cycle only; readback 0xAABB3344.
- Reset asserted the cycle after an accepted m1 read → m1_readdatavalid never pulses; all outputs hold reset values; after release first tie goes to m0.
- m0 read and m0 write high together → treated as write, no readdatavalid.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared owner-state type and master ids for the ROM port arbiter
package rom_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } owner_state_t;

    localparam logic MASTER_CPU   = 1'b0;
    localparam logic MASTER_FETCH = 1'b1;

    function automatic owner_state_t own_state(input logic master);
        return master ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/rom_arb_rr_grant.sv
// rtl/rom_arb_rr_grant.sv - combinational round-robin grant with bounded hold window
module rom_rr_grant
    import rom_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
    input  owner_state_t      i_state,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic [HOLD_W-1:0] i_hold_cnt,
    input  logic              i_last_grant,
    output logic              o_grant0,
    output logic              o_grant1,
    output owner_state_t      o_next_state,
    output logic [HOLD_W-1:0] o_next_hold_cnt
);

    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);

    logic w_owner;
    logic w_req_own;
    logic w_req_oth;
    logic w_any;
    logic w_sel;
    logic w_keep;

    assign w_owner   = (i_state == ST_OWN1);
    assign w_req_own = w_owner ? i_req1 : i_req0;
    assign w_req_oth = w_owner ? i_req0 : i_req1;

    always_comb begin
        w_any           = 1'b0;
        w_sel           = MASTER_CPU;
        w_keep          = 1'b0;
        o_grant0        = 1'b0;
        o_grant1        = 1'b0;
        o_next_state    = ST_IDLE;
        o_next_hold_cnt = '0;

        if (i_state == ST_IDLE) begin
            if (i_req0 && i_req1) begin
                w_any = 1'b1;
                w_sel = ~i_last_grant;
            end else if (i_req0) begin
                w_any = 1'b1;
                w_sel = MASTER_CPU;
            end else if (i_req1) begin
                w_any = 1'b1;
                w_sel = MASTER_FETCH;
            end
        end else begin
            // Owner keeps the port until its window is used up and the other side is waiting.
            if (w_req_own && (!w_req_oth || (i_hold_cnt < HOLD_LIMIT))) begin
                w_any  = 1'b1;
                w_sel  = w_owner;
                w_keep = 1'b1;
            end else if (w_req_oth) begin
                w_any = 1'b1;
                w_sel = ~w_owner;
            end
        end

        if (w_any) begin
            o_grant0     = (w_sel == MASTER_CPU);
            o_grant1     = (w_sel == MASTER_FETCH);
            o_next_state = own_state(w_sel);
            if (w_keep) begin
                o_next_hold_cnt = (i_hold_cnt >= HOLD_LIMIT) ? HOLD_LIMIT : i_hold_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - two-master arbiter for the shared 1024x32 ROM with 1-cycle read return
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int BE_W     = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_m0_read,
    input  logic              i_m0_write,
    input  logic [ADDR_W-1:0] i_m0_address,
    input  logic [DATA_W-1:0] i_m0_writedata,
    input  logic [BE_W-1:0]   i_m0_byteenable,
    output logic              o_m0_waitrequest,
    output logic [DATA_W-1:0] o_m0_readdata,
    output logic              o_m0_readdatavalid,
    input  logic              i_m1_read,
    input  logic [ADDR_W-1:0] i_m1_address,
    output logic              o_m1_waitrequest,
    output logic [DATA_W-1:0] o_m1_readdata,
    output logic              o_m1_readdatavalid,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [BE_W-1:0]   o_mem_byteenable,
    output logic              o_mem_chipselect,
    output logic              o_mem_write,
    output logic              o_mem_debugaccess,
    output logic [DATA_W-1:0] o_mem_writedata,
    input  logic [DATA_W-1:0] i_mem_readdata
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    owner_state_t      r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_last_grant;
    logic              r_run;
    logic              r_rd_pend;
    logic              r_rd_owner;
    logic [ADDR_W-1:0] r_mem_addr;

    owner_state_t      w_next_state;
    logic [HOLD_W-1:0] w_next_hold_cnt;
    logic              w_req0;
    logic              w_req1;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_any_grant;
    logic              w_rd_accept;
    logic [ADDR_W-1:0] w_sel_addr;

    // r_run keeps both masters waiting until the first clock after reset is released.
    assign w_req0 = r_run & (i_m0_read | i_m0_write);
    assign w_req1 = r_run & i_m1_read;

    rom_rr_grant #(
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (HOLD_W)
    ) u_grant (
        .i_state         (r_state),
        .i_req0          (w_req0),
        .i_req1          (w_req1),
        .i_hold_cnt      (r_hold_cnt),
        .i_last_grant    (r_last_grant),
        .o_grant0        (w_grant0),
        .o_grant1        (w_grant1),
        .o_next_state    (w_next_state),
        .o_next_hold_cnt (w_next_hold_cnt)
    );

    assign w_any_grant = w_grant0 | w_grant1;
    assign w_rd_accept = w_grant1 | (w_grant0 & ~i_m0_write);
    assign w_sel_addr  = w_grant1 ? i_m1_address : i_m0_address;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_hold_cnt   <= '0;
            r_last_grant <= MASTER_FETCH;
            r_run        <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_rd_owner   <= MASTER_CPU;
            r_mem_addr   <= '0;
        end else begin
            r_run      <= 1'b1;
            r_state    <= w_next_state;
            r_hold_cnt <= w_next_hold_cnt;
            r_rd_pend  <= w_rd_accept;
            r_rd_owner <= w_grant1;
            if (w_any_grant) begin
                r_last_grant <= w_grant1;
                r_mem_addr   <= w_sel_addr;
            end
        end
    end

    assign o_m0_waitrequest = ~w_grant0;
    assign o_m1_waitrequest = ~w_grant1;

    assign o_mem_address     = w_any_grant ? w_sel_addr : r_mem_addr;
    assign o_mem_byteenable  = w_grant1 ? {BE_W{1'b1}} : (w_grant0 ? i_m0_byteenable : '0);
    assign o_mem_writedata   = w_grant0 ? i_m0_writedata : '0;
    assign o_mem_chipselect  = w_any_grant;
    assign o_mem_write       = w_grant0 & i_m0_write;
    assign o_mem_debugaccess = w_grant0 & i_m0_write;

    // The ROM output is combinational one cycle after the address, so it is steered straight through.
    assign o_m0_readdatavalid = r_rd_pend & (r_rd_owner == MASTER_CPU);
    assign o_m1_readdatavalid = r_rd_pend & (r_rd_owner == MASTER_FETCH);
    assign o_m0_readdata      = o_m0_readdatavalid ? i_mem_readdata : '0;
    assign o_m1_readdata      = o_m1_readdatavalid ? i_mem_readdata : '0;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb/tb_rom_port_arbiter.sv - self-checking bench for rom_port_arbiter
module tb_rom_port_arbiter;

    localparam int MAX_HOLD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_read, m0_write, m1_read;
    logic [9:0]  m0_address, m1_address;
    logic [31:0] m0_writedata;
    logic [3:0]  m0_be;
    logic [31:0] mem_rdata;
    logic        mem_init;

    logic        w_m0_wait, w_m0_valid, w_m1_wait, w_m1_valid;
    logic [31:0] w_m0_rdata, w_m1_rdata, w_mem_wd;
    logic [9:0]  w_mem_addr;
    logic [3:0]  w_mem_be;
    logic        w_mem_cs, w_mem_we, w_mem_dbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rom_port_arbiter #(.ADDR_W(10), .DATA_W(32), .BE_W(4), .MAX_HOLD(MAX_HOLD)) dut (
        .i_clk              (clk),
        .i_reset            (rst),
        .i_m0_read          (m0_read),
        .i_m0_write         (m0_write),
        .i_m0_address       (m0_address),
        .i_m0_writedata     (m0_writedata),
        .i_m0_byteenable    (m0_be),
        .o_m0_waitrequest   (w_m0_wait),
        .o_m0_readdata      (w_m0_rdata),
        .o_m0_readdatavalid (w_m0_valid),
        .i_m1_read          (m1_read),
        .i_m1_address       (m1_address),
        .o_m1_waitrequest   (w_m1_wait),
        .o_m1_readdata      (w_m1_rdata),
        .o_m1_readdatavalid (w_m1_valid),
        .o_mem_address      (w_mem_addr),
        .o_mem_byteenable   (w_mem_be),
        .o_mem_chipselect   (w_mem_cs),
        .o_mem_write        (w_mem_we),
        .o_mem_debugaccess  (w_mem_dbg),
        .o_mem_writedata    (w_mem_wd),
        .i_mem_readdata     (mem_rdata)
    );

    function automatic logic [31:0] init_word(input int a);
        if (a == 5)  return 32'hDEADBEEF;
        if (a == 16) return 32'hAABBCCDD;
        return (32'(a) * 32'h9E3779B1) ^ 32'h0F0F1234;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // ROM behaviour: word write-first, read data appears one clock after the address.
    logic [31:0] mem [1024];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
        end else if (w_mem_cs) begin
            if (w_mem_we) mem[w_mem_addr] <= merge(mem[w_mem_addr], w_mem_wd, w_mem_be);
            else          mem_rdata <= mem[w_mem_addr];
        end
    end

    // Reference model: who owns the port, how many consecutive grants it has had, pending read.
    logic [31:0] ref_mem [1024];
    int          m_owner, m_streak, m_last, m_run, m_pend_owner;
    bit          m_pend;
    logic [31:0] m_pend_data;
    logic [9:0]  m_last_addr;

    task automatic model_reset();
        m_owner = -1; m_streak = 0; m_last = 1; m_run = 0;
        m_pend = 1'b0; m_pend_owner = 0; m_pend_data = '0; m_last_addr = '0;
    endtask

    function automatic int model_grant(input bit r0, input bit r1);
        bit ro, rx;
        if (m_run == 0) return -1;
        if (m_owner < 0) begin
            if (r0 && r1) return 1 - m_last;
            if (r0) return 0;
            if (r1) return 1;
            return -1;
        end
        ro = (m_owner == 0) ? r0 : r1;
        rx = (m_owner == 0) ? r1 : r0;
        if (ro && (!rx || m_streak < MAX_HOLD)) return m_owner;
        if (rx) return 1 - m_owner;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare DUT against model, advance model, wait for next negedge.
    task automatic step(input bit rst_v, input bit r0, input bit w0, input logic [9:0] a0,
                        input logic [31:0] d0, input logic [3:0] be0, input bit r1,
                        input logic [9:0] a1, output int dg);
        int          g;
        logic [9:0]  addr;
        logic        v0, v1;
        rst = rst_v; m0_read = r0; m0_write = w0; m0_address = a0;
        m0_writedata = d0; m0_be = be0; m1_read = r1; m1_address = a1;
        if (rst_v) model_reset();
        #1;
        g  = model_grant(r0 | w0, r1);
        dg = !w_m0_wait ? 0 : (!w_m1_wait ? 1 : -1);
        v0 = m_pend && (m_pend_owner == 0);
        v1 = m_pend && (m_pend_owner == 1);
        addr = (g == 1) ? a1 : ((g == 0) ? a0 : m_last_addr);
        check("m0_waitrequest", 32'(w_m0_wait), 32'(g != 0));
        check("m1_waitrequest", 32'(w_m1_wait), 32'(g != 1));
        check("mem_chipselect", 32'(w_mem_cs), 32'(g >= 0));
        check("mem_write", 32'(w_mem_we), 32'(g == 0 && w0));
        check("mem_debugaccess", 32'(w_mem_dbg), 32'(g == 0 && w0));
        check("mem_address", 32'(w_mem_addr), 32'(addr));
        if (g == 1) check("mem_be_m1", 32'(w_mem_be), 32'hF);
        if (g == 0) check("mem_be_m0", 32'(w_mem_be), 32'(be0));
        if (g == 0 && w0) check("mem_writedata", w_mem_wd, d0);
        check("m0_readdatavalid", 32'(w_m0_valid), 32'(v0));
        check("m1_readdatavalid", 32'(w_m1_valid), 32'(v1));
        check("m0_readdata", w_m0_rdata, v0 ? m_pend_data : 32'h0);
        check("m1_readdata", w_m1_rdata, v1 ? m_pend_data : 32'h0);
        m_pend = 1'b0;
        if (g >= 0) begin
            if (g == 0 && w0) begin
                ref_mem[addr] = merge(ref_mem[addr], d0, be0);
            end else begin
                m_pend = 1'b1; m_pend_owner = g; m_pend_data = ref_mem[addr];
            end
            m_last_addr = addr;
            if (g == m_owner) m_streak = (m_streak < MAX_HOLD) ? m_streak + 1 : MAX_HOLD;
            else begin m_owner = g; m_streak = 1; end
            m_last = g;
        end else begin
            m_owner = -1;
        end
        m_run = rst_v ? 0 : 1;
        @(negedge clk);
    endtask

    initial begin
        int          dg, idx, m0_wait, m1_before;
        bit          p0, p1, m0_pend, r0, w0, r1;
        logic [9:0]  a0, a1;
        logic [31:0] d0;
        logic [3:0]  be0;

        rst = 1'b1; mem_init = 1'b1;
        m0_read = 0; m0_write = 0; m1_read = 0;
        m0_address = '0; m1_address = '0; m0_writedata = '0; m0_be = '0;
        model_reset();
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        @(negedge clk);
        mem_init = 1'b0;

        // Reset holds every output quiet even with requests present.
        step(1, 1, 0, 10'h003, 0, 4'hF, 1, 10'h007, dg);
        step(1, 1, 1, 10'h003, 0, 4'hF, 1, 10'h007, dg);

        // Lone m0 read; first cycle after release must still wait.
        step(0, 1, 0, 10'h005, 0, 4'hF, 0, 0, dg);
        step(0, 1, 0, 10'h005, 0, 4'hF, 0, 0, dg);
        check("t1_valid", 32'(w_m0_valid), 32'h1);
        check("t1_rdata", w_m0_rdata, 32'hDEADBEEF);
        check("t1_m1_valid", 32'(w_m1_valid), 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0, dg);

        // Simultaneous single-shot requests alternate, m0 first.
        step(1, 0, 0, 0, 0, 0, 0, 0, dg);
        step(0, 1, 0, 10'h001, 0, 4'hF, 1, 10'h201, dg);
        for (int c = 0; c < 6; c++) begin
            step(0, (c % 2) == 0, 0, 10'(c), 0, 4'hF, (c == 0) || (c % 2) == 1, 10'(10'h200 + c), dg);
            check("t2_alternate", 32'(dg), 32'(c % 2));
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, dg);

        // Hold window: m1 streams 10 reads, m0 arrives in cycle 1.
        step(1, 0, 0, 0, 0, 0, 0, 0, dg);
        step(0, 0, 0, 0, 0, 0, 0, 0, dg);
        idx = 0; m0_pend = 1'b1; m0_wait = 0; m1_before = -1;
        for (int c = 0; c < 30 && (idx < 10 || m0_pend); c++) begin
            r0 = (c >= 1) && m0_pend;
            step(0, r0, 0, 10'h020, 0, 4'hF, idx < 10, 10'(10'h100 + idx), dg);
            if (r0 && dg != 0) m0_wait++;
            if (dg == 0) begin m0_pend = 1'b0; m1_before = idx; end
            if (dg == 1) idx++;
        end
        check("t3_m1_burst", 32'(m1_before), 32'd4);
        check("t3_m0_wait_le4", 32'(m0_wait <= 4), 32'h1);
        check("t3_m1_done", 32'(idx), 32'd10);
        step(0, 0, 0, 0, 0, 0, 0, 0, dg);

        // Byte-enabled write then readback.
        step(0, 0, 1, 10'h010, 32'h11223344, 4'b0011, 0, 0, dg);
        step(0, 1, 0, 10'h010, 0, 4'hF, 0, 0, dg);
        check("t4_write_once", 32'(w_mem_we), 32'h0);
        check("t4_readback", w_m0_rdata, 32'hAABB3344);
        step(0, 0, 0, 0, 0, 0, 0, 0, dg);

        // Reset right after an accepted m1 read drops the response.
        step(0, 0, 0, 0, 0, 0, 1, 10'h100, dg);
        step(1, 0, 0, 0, 0, 0, 0, 0, dg);
        check("t5_no_valid", 32'(w_m1_valid), 32'h0);
        step(1, 0, 0, 0, 0, 0, 0, 0, dg);
        step(0, 1, 0, 10'h002, 0, 4'hF, 1, 10'h102, dg);
        check("t5_release_wait", 32'(dg), 32'hFFFFFFFF);
        step(0, 1, 0, 10'h002, 0, 4'hF, 1, 10'h102, dg);
        check("t5_tie_m0", 32'(dg), 32'h0);
        step(0, 0, 0, 0, 0, 0, 1, 10'h102, dg);

        // Read and write together is a write.
        step(0, 1, 1, 10'h030, 32'hCAFEF00D, 4'hF, 0, 0, dg);
        step(0, 0, 0, 0, 0, 0, 0, 0, dg);
        check("t6_no_valid", 32'(w_m0_valid), 32'h0);

        // Random traffic; masters hold a request until it is accepted.
        p0 = 0; p1 = 0; r0 = 0; w0 = 0; r1 = 0; a0 = 0; a1 = 0; d0 = 0; be0 = 0;
        for (int c = 0; c < 400; c++) begin
            if (!p0 && ($urandom % 4) != 0) begin
                p0 = 1;
                case ($urandom % 3)
                    0: begin r0 = 1; w0 = 0; end
                    1: begin r0 = 0; w0 = 1; end
                    default: begin r0 = 1; w0 = 1; end
                endcase
                a0 = 10'($urandom % 16); d0 = $urandom; be0 = 4'($urandom);
            end else if (!p0) begin
                r0 = 0; w0 = 0;
            end
            if (!p1 && ($urandom % 5) != 0) begin
                p1 = 1; r1 = 1; a1 = 10'($urandom % 16);
            end else if (!p1) begin
                r1 = 0;
            end
            if (($urandom % 64) == 0) begin
                step(1, r0, w0, a0, d0, be0, r1, a1, dg);
                p0 = 0; p1 = 0; r0 = 0; w0 = 0; r1 = 0;
            end else begin
                step(0, r0, w0, a0, d0, be0, r1, a1, dg);
                if (dg == 0) begin p0 = 0; r0 = 0; w0 = 0; end
                if (dg == 1) begin p1 = 0; r1 = 0; end
            end
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, dg);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
